// File: rtl/mem_pkg.sv
// Shared FSM encoding, wait-counter width and address-check field positions
// for unified_mem_responder and its storage array.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W     = 4;
  localparam int ALIGN_MSB = 1;  // addr[ALIGN_MSB:0] selects a byte inside the word
  localparam int WORD_LSB  = 2;  // first bit of the word index

  // Misaligned, or any address bit above the word index is set.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] w_hi;
    w_hi = addr >> (addr_w + WORD_LSB);
    return (addr[ALIGN_MSB:0] != '0) || (w_hi != '0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// 2^ADDR_W x 32-bit storage: synchronous per-byte-lane write, combinational read.
// The read port therefore returns the pre-write word during a write cycle.
module mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/unified_mem_responder.sv
// Single-port memory responder with a fixed LATENCY-cycle wait before each response.
// Define UNIFIED_MEM_ERR_CHECK_EN to fault misaligned / out-of-range accesses.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | req_ready high; a valid request is latched and accepted
//   ST_WAIT | counting down the remaining wait cycles
//   ST_RESP | rsp_valid pulse; read data presented, write committed
module unified_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic             w_accept;
  logic             w_err;
  logic             w_mem_we;
  logic [31:0]      w_mem_rdata;

  // Outputs are gated by rst so an aborted request neither responds nor writes.
  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = CNT_W'(LATENCY);
          w_state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef UNIFIED_MEM_ERR_CHECK_EN
  assign w_err = addr_fault(r_addr, ADDR_W);
`else
  // Byte offset and bits above the word index are don't-care: the address wraps.
  logic w_unused_addr;
  assign w_unused_addr = ^{r_addr[1:0], r_addr[31:ADDR_W+2]};
  assign w_err = 1'b0;
`endif

  assign rsp_valid = (r_state == ST_RESP) && !rst;
  assign rsp_err   = rsp_valid && w_err;
  assign rsp_rdata = (rsp_valid && !w_err) ? w_mem_rdata : 32'h0;
  assign w_mem_we  = rsp_valid && r_we && !w_err;

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_be    (r_be),
    .i_addr  (r_addr[ADDR_W+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_unified_mem_responder.sv
// Bench for unified_mem_responder: directed cases plus randomized traffic
// checked against a word-array model; a second instance runs with LATENCY=0.
module tb_unified_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int NW  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_z, req_we_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [3:0]  req_be_z;
  logic        req_ready_z, rsp_valid_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_mem   [0:NW-1];
  bit          m_known [0:NW-1];

  always #5 clk = ~clk;

  unified_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  unified_mem_responder #(.ADDR_W(AW), .LATENCY(0)) u_dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_we(req_we_z), .req_addr(req_addr_z),
    .req_wdata(req_wdata_z), .req_be(req_be_z), .req_ready(req_ready_z),
    .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_fault(input logic [31:0] a);
`ifdef UNIFIED_MEM_ERR_CHECK_EN
    return (a % 4 != 0) || (a >= 32'(NW * 4));
`else
    return 1'b0;
`endif
  endfunction

  // Reference: returns the word as it was, then applies the store.
  task automatic model_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd,
                          output bit err, output bit known);
    int idx;
    idx   = int'((a / 4) % NW);
    err   = m_fault(a);
    known = err || m_known[idx];
    rd    = err ? 32'h0 : m_mem[idx];
    if (we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
      if (be == 4'hf) m_known[idx] = 1'b1;
    end
  endtask

  task automatic do_op(input string tag, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, output logic [31:0] got);
    logic [31:0] erd;
    bit eerr, kn;
    int k;
    model_op(we, a, wd, be, erd, eerr, kn);
    @(negedge clk);
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_idle"}, {31'b0, rsp_valid}, 32'd0);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k <= 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(LAT + 1));
    got = rsp_rdata;
    if (k <= 40) begin
      chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, eerr});
      if (kn) chk({tag, "_rd"}, rsp_rdata, erd);
    end
  endtask

  // Accept a write, then pulse rst after n_negs cycles (1 = in WAIT, LAT+1 = in RESP).
  task automatic abort_op(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input int n_negs);
    int pulses;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = wd; req_be = 4'hf;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n_negs - 1) @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, "_novld"}, {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) pulses++;
      @(negedge clk);
    end
    chk({tag, "_nrsp"}, 32'(pulses), 32'd0);
  endtask

  // req_valid held for 10 cycles with a new address each cycle.
  task automatic stream_test();
    int q_due[$];
    logic [31:0] q_dat[$];
    int busy_until, n_rsp, n_acc;
    bit rdy_e, exp_v, eerr, kn;
    logic [31:0] a, erd;
    busy_until = -1; n_rsp = 0; n_acc = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rdy_e = (i > busy_until);
      chk("strm_rdy", {31'b0, req_ready}, {31'b0, rdy_e});
      exp_v = (q_due.size() > 0) && (q_due[0] == i);
      chk("strm_vld", {31'b0, rsp_valid}, {31'b0, exp_v});
      if (rsp_valid) n_rsp++;
      if (exp_v) begin
        chk("strm_rd", rsp_rdata, q_dat[0]);
        void'(q_due.pop_front());
        void'(q_dat.pop_front());
      end
      if (i < 10) begin
        a = 32'($urandom_range(0, 15)) * 4;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom; req_be = 4'hf;
        if (rdy_e) begin
          model_op(1'b0, a, 32'h0, 4'h0, erd, eerr, kn);
          q_due.push_back(i + LAT + 1);
          q_dat.push_back(erd);
          busy_until = i + LAT + 1;
          n_acc++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    chk("strm_nrsp", 32'(n_rsp), 32'(n_acc));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int sel;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rdy", {31'b0, req_ready}, 32'd1);
    chk("rst_vld", {31'b0, rsp_valid}, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);

    do_op("wr_beef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hf, got);
    do_op("rd_beef", 1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("beef_val", got, 32'hDEADBEEF);
    do_op("wr_aa", 1'b1, 32'h10, 32'h000000AA, 4'h1, got);
    do_op("rd_aa", 1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("aa_val", got, 32'hDEADBEAA);
    do_op("wr_be0", 1'b1, 32'h10, 32'h12345678, 4'h0, got);
    do_op("rd_be0", 1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("be0_val", got, 32'hDEADBEAA);

    do_op("wr_mis", 1'b1, 32'h12, 32'h11223344, 4'hf, got);
    do_op("rd_mis", 1'b0, 32'h10, 32'h0, 4'h0, got);
`ifdef UNIFIED_MEM_ERR_CHECK_EN
    chk("mis_val", got, 32'hDEADBEAA);
`else
    chk("mis_val", got, 32'h11223344);
`endif
    do_op("wr_oor", 1'b1, 32'h1010, 32'h55AA55AA, 4'hf, got);
    do_op("rd_oor", 1'b0, 32'h10, 32'h0, 4'h0, got);
`ifdef UNIFIED_MEM_ERR_CHECK_EN
    chk("oor_val", got, 32'hDEADBEAA);
`else
    chk("oor_val", got, 32'h55AA55AA);
`endif

    abort_op("ab_wait", 32'h10, 32'h0BADF00D, 1);
    do_op("rd_abw", 1'b0, 32'h10, 32'h0, 4'h0, got);
    abort_op("ab_resp", 32'h10, 32'hFEEDFACE, LAT + 1);
    do_op("rd_abr", 1'b0, 32'h10, 32'h0, 4'h0, got);

    for (int w = 0; w < 16; w++) begin
      do_op("init", 1'b1, 32'(w * 4), $urandom, 4'hf, got);
    end
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 15)) * 4;
      sel = $urandom_range(0, 7);
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = a | (32'h1 << $urandom_range(12, 31));
      do_op("rnd", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), got);
    end

    stream_test();

    @(negedge clk);
    req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 32'h10;
    req_wdata_z = 32'hCAFEF00D; req_be_z = 4'hf;
    chk("z_rdy0", {31'b0, req_ready_z}, 32'd1);
    @(negedge clk);
    chk("z_vld1", {31'b0, rsp_valid_z}, 32'd1);
    chk("z_rdy1", {31'b0, req_ready_z}, 32'd0);
    req_we_z = 1'b0;
    @(negedge clk);
    chk("z_vld2", {31'b0, rsp_valid_z}, 32'd0);
    chk("z_rdy2", {31'b0, req_ready_z}, 32'd1);
    @(negedge clk);
    chk("z_vld3", {31'b0, rsp_valid_z}, 32'd1);
    chk("z_rd3", rsp_rdata_z, 32'hCAFEF00D);
    req_valid_z = 1'b0;
    @(negedge clk);
    chk("z_vld4", {31'b0, rsp_valid_z}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_responder.md
UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the number of word-index bits (memory depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the wait cycles between request acceptance and response (legal range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  controller presents a memory request.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read (instruction fetch or load).
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data.
REQ-009 SHALL have port req_be  input  4  byte enables for writes; bit i enables byte lane i.
REQ-010 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse marking a completed request.
REQ-012 SHALL have port rsp_rdata  output  32  read data, valid only while rsp_valid is high.
REQ-013 SHALL have port rsp_err  output  1  request faulted, valid only while rsp_valid is high.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, and RESP.
REQ-015 SHALL assert req_ready only in IDLE.
REQ-016 SHALL accept a request when req_valid and req_ready are both high, latching we, addr, wdata, and be.
REQ-017 SHALL transition IDLE->WAIT on accept with the wait counter loaded to LATENCY; when LATENCY=0 it SHALL go IDLE->RESP directly.
REQ-018 SHALL decrement the counter each cycle in WAIT and go WAIT->RESP on the cycle the counter equals 1.
REQ-019 SHALL hold rsp_valid high for exactly the one RESP cycle, then return to IDLE, giving a total of LATENCY+1 cycles from accept to rsp_valid.
REQ-020 SHALL perform writes in the RESP cycle, updating only the lanes whose be bit is set; be=0000 SHALL complete with no change.
REQ-021 SHALL return mem[addr[ADDR_W+1:2]] as it stood before the RESP-cycle write (read-before-write).
REQ-022 SHALL ignore all request inputs while not in IDLE; a req_valid held high is re-sampled in IDLE only.
REQ-023 SHALL drive rsp_rdata to 0 whenever rsp_valid is low or rsp_err is high.
REQ-024 SHALL support back-to-back operation: the request presented in the IDLE cycle after RESP is accepted, giving a minimum spacing of LATENCY+2 cycles.

Reset
REQ-025 SHALL, on rst, force state=IDLE, counter=0, req_ready=1 in the next cycle, rsp_valid=0, rsp_err=0, and rsp_rdata=0.
REQ-026 SHALL abort an in-flight request on reset mid-operation (WAIT or RESP) with no write and no response; memory contents SHALL NOT be cleared.

Configuration
REQ-027 SHALL, with UNIFIED_MEM_ERR_CHECK_EN defined, flag rsp_err=1 and suppress any write when the access is misaligned (addr[1:0]!=0) or out of range (addr[31:ADDR_W+2]!=0).
REQ-028 SHALL, without UNIFIED_MEM_ERR_CHECK_EN, tie rsp_err to 0, ignore addr[1:0], and wrap high address bits modulo the memory depth.

Structure
REQ-029 SHALL place the FSM state enum, the counter width constant (4), and the error-check field positions in shared package mem_pkg.
REQ-030 SHALL contain exactly one sub-module, mem_array: a synchronous byte-enable write / combinational read storage of 2^ADDR_W x 32 bits.

Verification
REQ-031 SHALL cover: reset, then a write of 0xDEADBEEF, be=1111, to 0x10, then a read of 0x10 -> rsp_valid 3 cycles after each accept (LATENCY=2) and rdata=0xDEADBEEF.
REQ-032 SHALL cover: a write of 0x000000AA, be=0001, to 0x10 over the prior data -> a subsequent read returns 0xDEADBEAA.
REQ-033 SHALL cover: with LATENCY=0, a read accepted at cycle n -> rsp_valid at n+1, req_ready low at n+1, and the next accept at n+2.
REQ-034 SHALL cover: with UNIFIED_MEM_ERR_CHECK_EN, a write to 0x12 -> rsp_err=1 and rdata=0, and a read of 0x10 afterwards is unchanged; without the macro the same write lands at word 4.
REQ-035 SHALL cover: rst asserted during WAIT of a write -> no rsp_valid, req_ready=1 the cycle after reset, and the target word unchanged.
REQ-036 SHALL cover: req_valid held high for 10 cycles with changing addr -> only addresses sampled in IDLE cycles are serviced, with one rsp_valid per accept.
